stopwatch_mode_ctrl: RTL and testbench

//  Mode controller and tick scheduler for the stopwatch minute/second counter datapath.

---
 rtl/stopwatch_mode_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_stopwatch_mode_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_mode_ctrl
//  Description : Mode controller and tick scheduler for the stopwatch
//                minute/second counter datapath. Conditions the board inputs
//                (2-flop sync, button debounce, press detect), runs the
//                RUN / PAUSED / ADJ_MIN / ADJ_SEC state machine and produces
//                the counter enables, count tick, clear pulse and blink phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_mode_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       min_en,
    output logic       sec_en,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       blink,
    output logic [1:0] mode
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] c_div_half = DIV_W'(CLK_HZ / 2 - 1);
    localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DEBOUNCE_CYC - 1);

    // State encoding doubles as the mode output encoding
    localparam logic [1:0] c_st_run     = 2'b00;
    localparam logic [1:0] c_st_paused  = 2'b01;
    localparam logic [1:0] c_st_adj_min = 2'b10;
    localparam logic [1:0] c_st_adj_sec = 2'b11;

    // Bit positions inside the synchronizer vectors
    localparam int c_bit_pause = 0;
    localparam int c_bit_reset = 1;
    localparam int c_bit_adj   = 2;
    localparam int c_bit_sel   = 3;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       w_press;      // [0] pause press, [1] reset press

    logic [DIV_W-1:0] r_div;
    logic             w_t1;
    logic             w_t2;

    logic [1:0]       r_state;
    logic             r_paused;
    logic             r_cnt_clr;
    logic             r_blink;

    logic             w_p_pause;
    logic             w_p_reset;
    logic             w_sw_adj;
    logic             w_sw_sel;
    logic             w_paused_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_in_adj;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for all four raw inputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= {sw_sel, sw_adj, btn_reset, btn_pause};
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button debounce and rising-edge press detect
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
            logic [DB_W-1:0] r_cnt;
            logic            r_db;
            logic            r_db_q;
            logic            w_sync;

            assign w_sync = r_sync2[gi];

            // Accept a new level only after DEBOUNCE_CYC consecutive
            // disagreeing samples; any agreement restarts the count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt  <= '0;
                    r_db   <= 1'b0;
                    r_db_q <= 1'b0;
                end else begin
                    r_db_q <= r_db;
                    if (w_sync == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_db  <= w_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_db & ~r_db_q;
        end
    endgenerate

    assign w_p_pause = w_press[c_bit_pause];
    assign w_p_reset = w_press[c_bit_reset];
    assign w_sw_adj  = r_sync2[c_bit_adj];
    assign w_sw_sel  = r_sync2[c_bit_sel];

    // ------------------------------------------------------------------------
    // Tick divider: t1 once per period, t2 twice per period (t1 included)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (r_cnt_clr || (r_div == c_div_last)) begin
            // Restarting on clear makes the first tick after it a full period
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_t1 = (r_div == c_div_last);
    assign w_t2 = (r_div == c_div_half) | w_t1;

    // ------------------------------------------------------------------------
    // Next-state logic: switches take priority, otherwise the pause flag
    // (including a toggle happening this cycle) picks PAUSED or RUN.
    // ------------------------------------------------------------------------
    assign w_paused_nxt = r_paused ^ w_p_pause;
    assign w_in_adj     = r_state[1];

    always_comb begin
        w_state_nxt = c_st_run;
        if (w_sw_adj) begin
            w_state_nxt = w_sw_sel ? c_st_adj_sec : c_st_adj_min;
        end else if (w_paused_nxt) begin
            w_state_nxt = c_st_paused;
        end
    end

    // ------------------------------------------------------------------------
    // Mode state machine, pause flag, clear pulse and blink phase
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_run;
            r_paused  <= 1'b0;
            r_cnt_clr <= 1'b1;      // counters are cleared while in reset
            r_blink   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_paused  <= w_paused_nxt;
            r_cnt_clr <= w_p_reset;
            if (!w_in_adj) begin
                r_blink <= 1'b0;
            end else if (w_t2) begin
                r_blink <= ~r_blink;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the current state; a pending clear masks the tick
    // ------------------------------------------------------------------------
    always_comb begin
        min_en   = 1'b0;
        sec_en   = 1'b0;
        cnt_tick = 1'b0;
        blink    = 1'b0;
        case (r_state)
            c_st_run: begin
                min_en   = 1'b1;
                sec_en   = 1'b1;
                cnt_tick = w_t1;
            end
            c_st_adj_min: begin
                min_en   = 1'b1;
                cnt_tick = w_t2;
                blink    = r_blink;
            end
            c_st_adj_sec: begin
                sec_en   = 1'b1;
                cnt_tick = w_t2;
                blink    = r_blink;
            end
            default: begin
                // PAUSED: everything stays low
            end
        endcase
        if (r_cnt_clr) begin
            cnt_tick = 1'b0;
        end
    end

    assign cnt_clr = r_cnt_clr;
    assign mode    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_mode_ctrl
//  Description : Directed self-checking bench for stopwatch_mode_ctrl with
//                CLK_HZ=20 and DEBOUNCE_CYC=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_mode_ctrl;

    localparam int c_clk_hz = 20;
    localparam int c_db_cyc = 4;

    logic       clk;
    logic       rst;
    logic       btn_pause;
    logic       btn_reset;
    logic       sw_adj;
    logic       sw_sel;
    logic       min_en;
    logic       sec_en;
    logic       cnt_tick;
    logic       cnt_clr;
    logic       blink;
    logic [1:0] mode;

    int n_total = 0;
    int n_bad   = 0;

    stopwatch_mode_ctrl #(
        .CLK_HZ       (c_clk_hz),
        .DEBOUNCE_CYC (c_db_cyc)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_reset (btn_reset),
        .sw_adj    (sw_adj),
        .sw_sel    (sw_sel),
        .min_en    (min_en),
        .sec_en    (sec_en),
        .cnt_tick  (cnt_tick),
        .cnt_clr   (cnt_clr),
        .blink     (blink),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance negedges until cnt_tick is seen; n = negedges advanced (limit on timeout)
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnt_tick && n < limit);
    endtask

    // Wait for the clear pulse; n = negedges advanced (limit on timeout)
    task automatic wait_clr(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnt_clr && n < limit);
    endtask

    // Hold the selected buttons for 'hold' cycles, then release and settle
    task automatic press(input bit p, input bit r, input int hold);
        btn_pause = p;
        btn_reset = r;
        repeat (hold) @(negedge clk);
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int n;
        int ticks;
        int b0;

        rst       = 1'b0;
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        sw_adj    = 1'b0;
        sw_sel    = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_clr", cnt_clr, 1);
        chk("rst_tick", cnt_tick, 0);
        chk("rst_blink", blink, 0);
        chk("rst_en", {min_en, sec_en}, 3);

        // ---------------- 1: release reset, tick every 20 ----------------
        rst = 1'b1;
        #1 chk("rel_clr_hi", cnt_clr, 1);
        @(negedge clk);
        chk("rel_clr_lo", cnt_clr, 0);
        wait_tick(60, n);
        chk("first_tick", n, 19);
        wait_tick(60, n);
        chk("run_gap", n, 20);
        chk("run_en", {min_en, sec_en}, 3);

        // ---------------- 2: bounce rejected, real presses toggle ----------------
        press(1'b1, 1'b0, 3);
        chk("bounce_mode", mode, 0);
        btn_pause = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mode != 2'b01 && n < 20);
        chk("pause_lat", n, 7);
        repeat (4) @(negedge clk);
        btn_pause = 1'b0;
        repeat (12) @(negedge clk);
        chk("paused_mode", mode, 1);
        chk("paused_en", {min_en, sec_en}, 0);
        ticks = 0;
        repeat (25) begin
            @(negedge clk);
            if (cnt_tick) ticks++;
        end
        chk("paused_ticks", ticks, 0);
        press(1'b1, 1'b0, 10);
        chk("resume_mode", mode, 0);

        // ---------------- 3: adjust modes ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        repeat (5) @(negedge clk);
        chk("adjmin_mode", mode, 2);
        chk("adjmin_en", {min_en, sec_en}, 2);
        wait_tick(60, n);
        b0 = blink;
        wait_tick(60, n);
        chk("adj_gap", n, 10);
        chk("blink_toggle", blink, b0 ^ 1);
        sw_sel = 1'b1;
        repeat (5) @(negedge clk);
        chk("adjsec_mode", mode, 3);
        chk("adjsec_en", {min_en, sec_en}, 1);

        // ---------------- 4: pause recorded during adjust ----------------
        sw_sel = 1'b0;
        repeat (5) @(negedge clk);
        press(1'b1, 1'b0, 10);
        chk("adj_pause_mode", mode, 2);
        sw_adj = 1'b0;
        repeat (5) @(negedge clk);
        chk("adj_exit_mode", mode, 1);
        chk("adj_exit_blink", blink, 0);
        press(1'b1, 1'b0, 10);
        chk("back_run", mode, 0);

        // ---------------- 5: counter clear ----------------
        btn_reset = 1'b1;
        wait_clr(20, n);
        chk("clr_lat", n, 7);
        chk("clr_mode", mode, 0);
        @(negedge clk);
        chk("clr_one_cyc", cnt_clr, 0);
        wait_tick(60, n);
        chk("clr_gap", n, 19);
        btn_reset = 1'b0;
        repeat (12) @(negedge clk);

        btn_pause = 1'b1;
        btn_reset = 1'b1;
        wait_clr(20, n);
        chk("both_clr", cnt_clr, 1);
        chk("both_mode", mode, 1);
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        repeat (12) @(negedge clk);
        press(1'b1, 1'b0, 10);
        chk("both_resume", mode, 0);

        // ---------------- 6: async reset mid-adjust, mid-debounce ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_mode", mode, 3);
        btn_pause = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_mode", mode, 0);
        chk("async_clr", cnt_clr, 1);
        chk("async_blink", blink, 0);
        chk("async_tick", cnt_tick, 0);
        btn_pause = 1'b0;
        sw_adj    = 1'b0;
        sw_sel    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_stray", mode, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
